rtc_calendar_alarm: RTL and testbench
=====================================

Name: rtc_calendar_alarm

Overview:
Parametrised timekeeping core for the next-generation board clock. It keeps BCD time and date with a full Gregorian leap rule, a configurable century window and a day-of-week counter. It adds NUM_ALARMS independent alarm channels, each with its own ring/snooze state machine. It sits between the tick divider and the display/key-handling logic, which drive it through a single field-write port.

Parameters:
NUM_ALARMS, 2, number of alarm channels (1..8)
CC_MIN, 8'h20, lowest century (BCD); era wraps to CC_MIN/YY=01
CC_MAX, 8'h30, highest century (BCD); year CC_MAX:00 is the last year
SNOOZE_MIN, 5, snooze length in minutes (1..59)
RING_SEC, 60, auto-stop after this many ticks of ringing (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
tick  in  1  one-cycle pulse, advance one second
wr_en  in  1  write strobe for time/date field
wr_field  in  3  0 sec, 1 min, 2 hour, 3 day, 4 month, 5 YY, 6 CC, 7 day-of-week
wr_data  in  8  BCD value (dow: binary 0..6, 0 = Sunday)
wr_err  out  1  one-cycle pulse: write rejected
sec, min, hour, day, mon, yy, cc  out  8 each  BCD time/date
dow  out  3  day of week
al_wr_en  in  1  alarm configuration strobe
al_idx  in  $clog2(NUM_ALARMS) (min 1)  channel to configure
al_hour, al_min  in  8 each  BCD alarm time
al_arm  in  1  armed flag written with the configuration
snooze, dismiss  in  1 each  one-cycle pulses from the key logic
ring  out  NUM_ALARMS  per-channel ringing
any_ring  out  1  OR of ring

Behaviour:
- Reset (clk edge with rst_n=0): 00:00:00, 01/01/CC_MIN:01, dow=1; all alarms 00:00, disarmed, IDLE; ring=0, wr_err=0.
- Tick: all fields cascade in the same cycle: sec 59->00 carries min; 59->00 carries hour; 23->00 carries day and dow; day at days_in_month->01 carries month; 12->01 carries YY; 99->00 carries CC. Outputs are registered and valid one cycle after the tick.
- Month lengths are 31/30, Feb 29 when (year%4==0 and YY!=00) or (YY==00 and CC%4==0); otherwise 28. Year is computed from BCD digits only; no multiplier or divider.
- Era wrap: a month carry out of Dec while CC=CC_MAX and YY=00 loads CC=CC_MIN, YY=01.
- wr_en has priority over tick in the same cycle; that tick is dropped.
- A write is rejected (no state change, wr_err=1 for 1 cycle) when:
  - a digit is >9;
  - the value is out of the field range (day 1..days_in_month of the current month/year; CC CC_MIN..CC_MAX; YY 00..99; dow 0..6);
  - the write would produce a year outside CC_MIN:00..CC_MAX:00.
- Month or year writes that leave day > new days_in_month clamp day to the maximum in the same cycle.
- Alarm channel FSM: IDLE, RINGING, SNOOZED.
  - IDLE->RINGING on a tick that leaves hour==al_hour, min==al_min, sec==00 while armed.
  - RINGING: ring=1.
    - dismiss->IDLE.
    - snooze->SNOOZED, snooze counter loaded with SNOOZE_MIN*60.
    - ring-tick counter reaching RING_SEC->IDLE.
  - SNOOZED: counter decrements per tick; at 0->RINGING (ring counter reloaded). dismiss->IDLE.
  - snooze/dismiss act on every channel in the qualifying state simultaneously. dismiss wins over snooze in the same cycle.
  - Disarm or reconfigure (al_wr_en for that idx) forces that channel to IDLE in the same cycle. Invalid alarm BCD is ignored silently.
  - A match tick in SNOOZED or RINGING is ignored (no restart).
- Reset mid-ring or mid-snooze returns every channel to IDLE, ring=0, next cycle.

Optional Feature:
ALARM_DOW_MASK_EN: when defined, each channel gains a 7-bit weekday mask, written through extra input al_dow_mask[6:0] with al_wr_en (reset 7'h7F). The IDLE->RINGING transition also requires mask[dow]. When undefined, the port is absent and alarms fire daily.

Decomposition:
- Package rtc_pkg holds:
  - field code constants;
  - alarm state encoding;
  - reset constants;
  - a days_in_month(mon, is_leap) function;
  - a BCD-increment function.
- Sub-module rtc_alarm_channel holds one FSM plus its snooze and ring counters. It is instantiated NUM_ALARMS times via generate. The calendar cascade stays in the top.

Test Plan:
- 23:59:59 31/12/2099, tick -> 00:00:00 01/01/2100, dow+1.
- 28/02/2100, 23:59:59 tick -> 01/03 (2100 not leap); 28/02/2400 at CC_MAX=8'h30 -> 29/02/2400.
- 23:59:59 31/12/3000 (CC_MAX=30), tick -> 00:00:00 01/01/2001.
- Write day=31 in month 04 -> wr_err pulse, day unchanged. Day=31 in Jan, then write month=02 in 2024 -> day=29.
- Alarm 0 armed 07:30, advance to 07:30:00 -> ring[0]=1. Snooze -> ring=0 for exactly 300 ticks, then ring=1. After RING_SEC=60 ticks -> ring=0.
- wr_en and tick in the same cycle -> write applied, no increment. Assert rst_n=0 while ringing -> ring=0 next cycle.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC calendar/alarm core: write field codes,
// alarm channel state encoding, reset values and BCD calendar helpers.
// Optional feature macro used by the core: ALARM_DOW_MASK_EN.
package rtc_pkg;

  localparam logic [2:0] F_SEC  = 3'd0;
  localparam logic [2:0] F_MIN  = 3'd1;
  localparam logic [2:0] F_HOUR = 3'd2;
  localparam logic [2:0] F_DAY  = 3'd3;
  localparam logic [2:0] F_MON  = 3'd4;
  localparam logic [2:0] F_YY   = 3'd5;
  localparam logic [2:0] F_CC   = 3'd6;
  localparam logic [2:0] F_DOW  = 3'd7;

  localparam logic [1:0] AL_IDLE    = 2'd0;
  localparam logic [1:0] AL_RINGING = 2'd1;
  localparam logic [1:0] AL_SNOOZED = 2'd2;

  localparam logic [7:0] RST_SEC      = 8'h00;
  localparam logic [7:0] RST_MIN      = 8'h00;
  localparam logic [7:0] RST_HOUR     = 8'h00;
  localparam logic [7:0] RST_DAY      = 8'h01;
  localparam logic [7:0] RST_MON      = 8'h01;
  localparam logic [7:0] RST_YY       = 8'h01;
  localparam logic [2:0] RST_DOW      = 3'd1;
  localparam logic [7:0] RST_AL_HOUR  = 8'h00;
  localparam logic [7:0] RST_AL_MIN   = 8'h00;
  localparam logic [6:0] RST_DOW_MASK = 7'h7F;

  // Both nibbles are decimal digits.
  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Increment a valid two-digit BCD value (99 is never incremented by callers).
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // 10*h + l is divisible by 4 iff (2*h[0] + l) mod 4 == 0.
  function automatic logic bcd_div4(input logic tens_lsb, input logic [1:0] units_lo);
    logic [1:0] r;
    r = units_lo + {tens_lsb, 1'b0};
    return r == 2'b00;
  endfunction

  function automatic logic is_leap(input logic [7:0] yy, input logic [7:0] cc);
    if (yy != 8'h00) return bcd_div4(yy[4], yy[1:0]);
    else             return bcd_div4(cc[4], cc[1:0]);
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] mon, input logic leap);
    case (mon)
      8'h02:                      return leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

endpackage

// File: rtl/rtc_alarm_channel.sv
// One alarm channel: stored alarm time/arm flag, IDLE/RINGING/SNOOZED FSM,
// snooze countdown and ring auto-stop counter. Counters advance on the same
// second strobe that advances the calendar.
// With ALARM_DOW_MASK_EN defined the channel also keeps a weekday mask.
module rtc_alarm_channel
  import rtc_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_wr,
  input  logic [7:0] cfg_hour,
  input  logic [7:0] cfg_min,
  input  logic       cfg_arm,
`ifdef ALARM_DOW_MASK_EN
  input  logic [6:0] cfg_dow_mask,
  input  logic [2:0] dow_next,
`endif
  input  logic       sec_adv,
  input  logic [7:0] hour_next,
  input  logic [7:0] min_next,
  input  logic [7:0] sec_next,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       ring
);

  localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_MIN * 60);
  localparam logic [7:0]  RING_LAST = 8'(RING_SEC - 1);

  logic [1:0]  state;
  logic [7:0]  al_hour_q;
  logic [7:0]  al_min_q;
  logic        armed;
  logic [11:0] snz_cnt;
  logic [7:0]  ring_cnt;
  logic        fire;

`ifdef ALARM_DOW_MASK_EN
  logic [6:0] mask_q;
  logic [7:0] mask_ext;

  // Day-of-week gate for the alarm match.
  always_comb begin
    mask_ext = {1'b0, mask_q};
    fire = armed && sec_adv && (sec_next == 8'h00) &&
           (hour_next == al_hour_q) && (min_next == al_min_q) && mask_ext[dow_next];
  end
`else
  // Alarm match on the second that lands on HH:MM:00.
  always_comb begin
    fire = armed && sec_adv && (sec_next == 8'h00) &&
           (hour_next == al_hour_q) && (min_next == al_min_q);
  end
`endif

  // Configuration, ring/snooze state machine and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= AL_IDLE;
      al_hour_q <= RST_AL_HOUR;
      al_min_q  <= RST_AL_MIN;
      armed     <= 1'b0;
      snz_cnt   <= '0;
      ring_cnt  <= '0;
`ifdef ALARM_DOW_MASK_EN
      mask_q    <= RST_DOW_MASK;
`endif
    end else if (cfg_wr) begin
      al_hour_q <= cfg_hour;
      al_min_q  <= cfg_min;
      armed     <= cfg_arm;
      state     <= AL_IDLE;
      snz_cnt   <= '0;
      ring_cnt  <= '0;
`ifdef ALARM_DOW_MASK_EN
      mask_q    <= cfg_dow_mask;
`endif
    end else begin
      case (state)
        AL_IDLE: begin
          if (fire) begin
            state    <= AL_RINGING;
            ring_cnt <= '0;
          end
        end
        AL_RINGING: begin
          if (dismiss) begin
            state <= AL_IDLE;
          end else if (snooze) begin
            state   <= AL_SNOOZED;
            snz_cnt <= SNZ_LOAD;
          end else if (sec_adv) begin
            if (ring_cnt == RING_LAST) state <= AL_IDLE;
            else                       ring_cnt <= ring_cnt + 8'd1;
          end
        end
        AL_SNOOZED: begin
          if (dismiss) begin
            state <= AL_IDLE;
          end else if (sec_adv) begin
            // Leaving on the tick that would take the count to zero.
            if (snz_cnt == 12'd1) begin
              state    <= AL_RINGING;
              ring_cnt <= '0;
            end else begin
              snz_cnt <= snz_cnt - 12'd1;
            end
          end
        end
        default: state <= AL_IDLE;
      endcase
    end
  end

  assign ring = (state == AL_RINGING);

endmodule

// File: rtl/rtc_calendar_alarm.sv
// BCD real-time clock/calendar with Gregorian leap rule, bounded century
// window with era wrap, day-of-week counter, a checked field-write port and
// NUM_ALARMS alarm channels.
// Optional feature macro: ALARM_DOW_MASK_EN (adds al_dow_mask weekday gating).
module rtc_calendar_alarm
  import rtc_pkg::*;
#(
  parameter int unsigned NUM_ALARMS = 2,
  parameter logic [7:0]  CC_MIN     = 8'h20,
  parameter logic [7:0]  CC_MAX     = 8'h30,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  wr_en,
  input  logic [2:0]            wr_field,
  input  logic [7:0]            wr_data,
  output logic                  wr_err,
  output logic [7:0]            sec,
  output logic [7:0]            min,
  output logic [7:0]            hour,
  output logic [7:0]            day,
  output logic [7:0]            mon,
  output logic [7:0]            yy,
  output logic [7:0]            cc,
  output logic [2:0]            dow,
  input  logic                  al_wr_en,
  input  logic [((NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1)-1:0] al_idx,
  input  logic [7:0]            al_hour,
  input  logic [7:0]            al_min,
  input  logic                  al_arm,
`ifdef ALARM_DOW_MASK_EN
  input  logic [6:0]            al_dow_mask,
`endif
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [NUM_ALARMS-1:0] ring,
  output logic                  any_ring
);

  localparam int unsigned IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic       leap_cur;
  logic [7:0] dim_cur;
  logic       sec_adv;

  // Tick-path next values
  logic [7:0] t_sec, t_min, t_hour, t_day, t_mon, t_yy, t_cc;
  logic [2:0] t_dow;
  logic       c_min, c_hour, c_day, c_mon, c_yy;

  // Write-path next values
  logic [7:0] w_sec, w_min, w_hour, w_day, w_mon, w_yy, w_cc;
  logic [2:0] w_dow;
  logic [7:0] dim_w;
  logic       wr_ok;
  logic       digits_ok;
  logic       al_ok;

  assign leap_cur = is_leap(yy, cc);
  assign dim_cur  = days_in_month(mon, leap_cur);
  assign sec_adv  = tick && !wr_en;

  // One-second cascade; every carry resolves in the same cycle.
  always_comb begin
    c_min  = (sec == 8'h59);
    c_hour = c_min && (min == 8'h59);
    c_day  = c_hour && (hour == 8'h23);
    c_mon  = c_day && (day == dim_cur);
    c_yy   = c_mon && (mon == 8'h12);

    t_sec  = c_min  ? 8'h00 : bcd_inc(sec);
    t_min  = c_min  ? ((min == 8'h59) ? 8'h00 : bcd_inc(min)) : min;
    t_hour = c_hour ? ((hour == 8'h23) ? 8'h00 : bcd_inc(hour)) : hour;
    t_day  = c_day  ? ((day == dim_cur) ? 8'h01 : bcd_inc(day)) : day;
    t_mon  = c_mon  ? ((mon == 8'h12) ? 8'h01 : bcd_inc(mon)) : mon;
    t_dow  = c_day  ? ((dow == 3'd6) ? 3'd0 : dow + 3'd1) : dow;
    t_yy   = yy;
    t_cc   = cc;
    if (c_yy) begin
      // Leaving the last year of the window restarts the era at CC_MIN:01.
      if ((cc == CC_MAX) && (yy == 8'h00)) begin
        t_cc = CC_MIN;
        t_yy = 8'h01;
      end else if (yy == 8'h99) begin
        t_yy = 8'h00;
        t_cc = bcd_inc(cc);
      end else begin
        t_yy = bcd_inc(yy);
      end
    end
  end

  // Field write validation, including day clamping for month/year changes.
  always_comb begin
    w_sec     = sec;
    w_min     = min;
    w_hour    = hour;
    w_day     = day;
    w_mon     = mon;
    w_yy      = yy;
    w_cc      = cc;
    w_dow     = dow;
    dim_w     = dim_cur;
    wr_ok     = 1'b0;
    digits_ok = bcd_ok(wr_data);
    case (wr_field)
      F_SEC: begin
        wr_ok = digits_ok && (wr_data <= 8'h59);
        w_sec = wr_data;
      end
      F_MIN: begin
        wr_ok = digits_ok && (wr_data <= 8'h59);
        w_min = wr_data;
      end
      F_HOUR: begin
        wr_ok  = digits_ok && (wr_data <= 8'h23);
        w_hour = wr_data;
      end
      F_DAY: begin
        wr_ok = digits_ok && (wr_data >= 8'h01) && (wr_data <= dim_cur);
        w_day = wr_data;
      end
      F_MON: begin
        wr_ok = digits_ok && (wr_data >= 8'h01) && (wr_data <= 8'h12);
        w_mon = wr_data;
        dim_w = days_in_month(wr_data, leap_cur);
      end
      F_YY: begin
        wr_ok = digits_ok && !((cc == CC_MAX) && (wr_data != 8'h00));
        w_yy  = wr_data;
        dim_w = days_in_month(mon, is_leap(wr_data, cc));
      end
      F_CC: begin
        wr_ok = digits_ok && (wr_data >= CC_MIN) && (wr_data <= CC_MAX) &&
                !((wr_data == CC_MAX) && (yy != 8'h00));
        w_cc  = wr_data;
        dim_w = days_in_month(mon, is_leap(yy, wr_data));
      end
      F_DOW: begin
        wr_ok = (wr_data <= 8'd6);
        w_dow = wr_data[2:0];
      end
      default: wr_ok = 1'b0;
    endcase
    if (day > dim_w) w_day = dim_w;
  end

  // Calendar registers: write has priority and swallows a coincident tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sec    <= RST_SEC;
      min    <= RST_MIN;
      hour   <= RST_HOUR;
      day    <= RST_DAY;
      mon    <= RST_MON;
      yy     <= RST_YY;
      cc     <= CC_MIN;
      dow    <= RST_DOW;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_ok;
      if (wr_en) begin
        if (wr_ok) begin
          sec  <= w_sec;
          min  <= w_min;
          hour <= w_hour;
          day  <= w_day;
          mon  <= w_mon;
          yy   <= w_yy;
          cc   <= w_cc;
          dow  <= w_dow;
        end
      end else if (tick) begin
        sec  <= t_sec;
        min  <= t_min;
        hour <= t_hour;
        day  <= t_day;
        mon  <= t_mon;
        yy   <= t_yy;
        cc   <= t_cc;
        dow  <= t_dow;
      end
    end
  end

  assign al_ok = bcd_ok(al_hour) && (al_hour <= 8'h23) &&
                 bcd_ok(al_min) && (al_min <= 8'h59);

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_alarm
    localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(i);
    logic cfg_wr;

    assign cfg_wr = al_wr_en && al_ok && (al_idx == MY_IDX);

    rtc_alarm_channel #(
      .SNOOZE_MIN (SNOOZE_MIN),
      .RING_SEC   (RING_SEC)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_wr       (cfg_wr),
      .cfg_hour     (al_hour),
      .cfg_min      (al_min),
      .cfg_arm      (al_arm),
`ifdef ALARM_DOW_MASK_EN
      .cfg_dow_mask (al_dow_mask),
      .dow_next     (t_dow),
`endif
      .sec_adv      (sec_adv),
      .hour_next    (t_hour),
      .min_next     (t_min),
      .sec_next     (t_sec),
      .snooze       (snooze),
      .dismiss      (dismiss),
      .ring         (ring[i])
    );
  end

  assign any_ring = |ring;

endmodule

// File: tb/tb_rtc_calendar_alarm.sv
// Directed bench for rtc_calendar_alarm (default parameters, no weekday mask).
module tb_rtc_calendar_alarm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       wr_en;
  logic [2:0] wr_field;
  logic [7:0] wr_data;
  logic       wr_err;
  logic [7:0] sec, min, hour, day, mon, yy, cc;
  logic [2:0] dow;
  logic       al_wr_en;
  logic [0:0] al_idx;
  logic [7:0] al_hour, al_min;
  logic       al_arm;
  logic       snooze, dismiss;
  logic [1:0] ring;
  logic       any_ring;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rtc_calendar_alarm #(
    .NUM_ALARMS (2),
    .CC_MIN     (8'h20),
    .CC_MAX     (8'h30),
    .SNOOZE_MIN (5),
    .RING_SEC   (60)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .wr_en    (wr_en),
    .wr_field (wr_field),
    .wr_data  (wr_data),
    .wr_err   (wr_err),
    .sec      (sec),
    .min      (min),
    .hour     (hour),
    .day      (day),
    .mon      (mon),
    .yy       (yy),
    .cc       (cc),
    .dow      (dow),
    .al_wr_en (al_wr_en),
    .al_idx   (al_idx),
    .al_hour  (al_hour),
    .al_min   (al_min),
    .al_arm   (al_arm),
    .snooze   (snooze),
    .dismiss  (dismiss),
    .ring     (ring),
    .any_ring (any_ring)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] f, input logic [7:0] d);
    wr_en = 1'b1; wr_field = f; wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    wr(3'd2, h);
    wr(3'd1, m);
    wr(3'd0, s);
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
    end
  endtask

  task automatic al_cfg(input logic idx, input logic [7:0] h, input logic [7:0] m, input logic arm);
    al_wr_en = 1'b1; al_idx = idx; al_hour = h; al_min = m; al_arm = arm;
    cycle();
    al_wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; wr_en = 1'b0; wr_field = '0; wr_data = '0;
    al_wr_en = 1'b0; al_idx = '0; al_hour = '0; al_min = '0; al_arm = 1'b0;
    snooze = 1'b0; dismiss = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;

    check("rst_time", {8'h0, hour, min, sec}, 32'h00000000);
    check("rst_date", {day, mon, cc, yy}, 32'h01012001);
    check("rst_dow", {29'h0, dow}, 32'd1);
    check("rst_ring", {29'h0, wr_err, ring}, 32'd0);

    // Century rollover 31/12/2099 23:59:59 -> 01/01/2100
    wr(3'd5, 8'h99); wr(3'd4, 8'h12); wr(3'd3, 8'h31);
    set_time(8'h23, 8'h59, 8'h59);
    wr(3'd7, 8'd3);
    check("wr_ok_err", {31'h0, wr_err}, 32'd0);
    do_ticks(1);
    check("c21_time", {8'h0, hour, min, sec}, 32'h00000000);
    check("c21_date", {day, mon, cc, yy}, 32'h01012100);
    check("c21_dow", {29'h0, dow}, 32'd4);

    // 2100 is not leap
    wr(3'd4, 8'h02); wr(3'd3, 8'h28);
    set_time(8'h23, 8'h59, 8'h59);
    do_ticks(1);
    check("feb2100", {16'h0, day, mon}, 32'h00000103);

    // 2400 is leap
    wr(3'd6, 8'h24); wr(3'd4, 8'h02); wr(3'd3, 8'h28);
    set_time(8'h23, 8'h59, 8'h59);
    do_ticks(1);
    check("feb2400", {day, mon, cc, yy}, 32'h29022400);

    // Move to 3000 (not leap): day 29 clamps to 28
    wr(3'd6, 8'h30);
    check("cc30_clamp", {day, mon, cc, yy}, 32'h28023000);
    wr(3'd5, 8'h01);
    check("yy_past_max_err", {31'h0, wr_err}, 32'd1);
    check("yy_past_max_keep", {24'h0, yy}, 32'h00);
    wr(3'd6, 8'h31);
    check("cc_hi_err", {31'h0, wr_err}, 32'd1);
    wr(3'd6, 8'h19);
    check("cc_lo_err", {31'h0, wr_err}, 32'd1);

    // Era wrap 31/12/3000 -> 01/01/2001, dow 6 -> 0
    wr(3'd4, 8'h12); wr(3'd3, 8'h31);
    set_time(8'h23, 8'h59, 8'h59);
    do_ticks(1);
    check("era_time", {8'h0, hour, min, sec}, 32'h00000000);
    check("era_date", {day, mon, cc, yy}, 32'h01012001);
    check("era_dow", {29'h0, dow}, 32'd0);

    // Day range and clamping
    wr(3'd4, 8'h04);
    wr(3'd3, 8'h31);
    check("day31_apr_err", {31'h0, wr_err}, 32'd1);
    check("day31_apr_keep", {16'h0, day, mon}, 32'h00000104);
    wr(3'd4, 8'h01); wr(3'd3, 8'h31); wr(3'd5, 8'h24);
    wr(3'd4, 8'h02);
    check("clamp_feb2024", {day, mon, cc, yy}, 32'h29022024);
    check("clamp_no_err", {31'h0, wr_err}, 32'd0);
    wr(3'd0, 8'h5A);
    check("bad_digit_err", {31'h0, wr_err}, 32'd1);
    check("bad_digit_keep", {24'h0, sec}, 32'h00);
    cycle();
    check("err_one_cycle", {31'h0, wr_err}, 32'd0);
    wr(3'd7, 8'd7);
    check("dow7_err", {31'h0, wr_err}, 32'd1);

    // Write and tick together: write wins, no increment
    tick = 1'b1;
    wr(3'd0, 8'h30);
    tick = 1'b0;
    check("wr_tick_prio", {8'h0, hour, min, sec}, 32'h00000030);

    // Alarm 0 at 07:30, snooze, auto-stop
    al_cfg(1'b0, 8'h07, 8'h30, 1'b1);
    set_time(8'h07, 8'h29, 8'h59);
    check("al_pre", {30'h0, ring}, 32'd0);
    do_ticks(1);
    check("al_fire", {29'h0, any_ring, ring}, 32'b101);
    snooze = 1'b1; cycle(); snooze = 1'b0;
    check("al_snoozed", {29'h0, any_ring, ring}, 32'd0);
    do_ticks(299);
    check("al_snz_299", {30'h0, ring}, 32'd0);
    do_ticks(1);
    check("al_snz_300", {30'h0, ring}, 32'b01);
    check("al_snz_time", {8'h0, hour, min, sec}, 32'h00073500);
    do_ticks(59);
    check("al_ring_59", {30'h0, ring}, 32'b01);
    do_ticks(1);
    check("al_ring_60", {29'h0, any_ring, ring}, 32'd0);

    // Both channels, dismiss clears both
    al_cfg(1'b1, 8'h07, 8'h30, 1'b1);
    set_time(8'h07, 8'h29, 8'h59);
    do_ticks(1);
    check("al_both", {30'h0, ring}, 32'b11);
    dismiss = 1'b1; snooze = 1'b1; cycle(); dismiss = 1'b0; snooze = 1'b0;
    check("al_dismiss", {30'h0, ring}, 32'd0);
    do_ticks(2);
    check("al_dismiss_hold", {30'h0, ring}, 32'd0);

    // Invalid config ignored, valid disarm forces IDLE
    set_time(8'h07, 8'h29, 8'h59);
    do_ticks(1);
    check("al_refire", {30'h0, ring}, 32'b11);
    al_cfg(1'b0, 8'h24, 8'h30, 1'b0);
    check("al_bad_cfg", {30'h0, ring}, 32'b11);
    al_cfg(1'b0, 8'h07, 8'h30, 1'b0);
    check("al_disarm", {30'h0, ring}, 32'b10);
    set_time(8'h07, 8'h29, 8'h59);
    do_ticks(1);
    check("al_disarmed", {30'h0, ring}, 32'b10);

    // Reset while ringing
    al_cfg(1'b0, 8'h07, 8'h30, 1'b1);
    set_time(8'h07, 8'h29, 8'h59);
    do_ticks(1);
    check("al_rearm", {30'h0, ring}, 32'b11);
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    check("rst_ring_off", {29'h0, any_ring, ring}, 32'd0);
    check("rst2_time", {8'h0, hour, min, sec}, 32'h00000000);
    check("rst2_date", {day, mon, cc, yy}, 32'h01012001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
